// File: rtl/screen_sequencer.sv
// Purpose: on start, draws FRAMES W x H images from a pixel ROM at a latched origin,
//          holds each one for HOLD cycles, then loops or stops, and exits early on userCont.
// Latency: start edge -> LOAD next cycle; romAddr leads plot/x/y by one cycle (ROM read latency).
// Backpressure: none; the VGA/ROM side always accepts a pixel. start is ignored while busy.
//
// Ports:
//   clk, stateReset     - clock and synchronous active-high reset
//   start               - begin a sequence (sampled in IDLE only)
//   x0, y0, frameBase   - origin and memorySel of frame 0, latched on accepted start
//   loopMode            - 1 = wrap to frame 0 after the last frame, 0 = one-shot
//   userCont            - exit request; the frame being drawn is always completed
//   romAddr, memorySel  - pixel ROM address and image select
//   x, y, plot          - VGA write port, one cycle behind romAddr
//   frameIdx, busy, done- current frame, not-IDLE flag, one-cycle end pulse
module screen_sequencer #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int W      = 160,
    parameter int H      = 120,
    parameter int ADDR_W = 15,
    parameter int FRAMES = 3,
    parameter int SEL_W  = 5,
    parameter int HOLD   = 12500000
) (
    input  logic                            clk,
    input  logic                            stateReset,
    input  logic                            start,
    input  logic [X_W-1:0]                  x0,
    input  logic [Y_W-1:0]                  y0,
    input  logic [SEL_W-1:0]                frameBase,
    input  logic                            loopMode,
    input  logic                            userCont,
    output logic [ADDR_W-1:0]               romAddr,
    output logic [SEL_W-1:0]                memorySel,
    output logic [X_W-1:0]                  x,
    output logic [Y_W-1:0]                  y,
    output logic                            plot,
    output logic [$clog2(FRAMES+1)-1:0]     frameIdx,
    output logic                            busy,
    output logic                            done
);
    localparam int FI_W = $clog2(FRAMES + 1);
    localparam int CW   = $clog2(W + 1);
    localparam int RW   = $clog2(H + 1);
    localparam int HW   = $clog2(HOLD + 1);

    localparam logic [CW-1:0]     COL_LAST   = CW'(W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(W * H - 1);
    localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD - 1);
    localparam logic [FI_W-1:0]   FRAME_LAST = FI_W'(FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;

    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [HW-1:0]     hold_q;
    logic [X_W-1:0]    x0_q;
    logic [Y_W-1:0]    y0_q;
    logic [SEL_W-1:0]  base_q;
    logic              loop_q;
    logic              exit_q;

    logic              draw_last;
    logic              hold_last;
    logic              frame_last;
    logic              exit_now;
    logic [FI_W-1:0]   next_frame;

    assign draw_last  = (romAddr == ADDR_LAST);
    assign hold_last  = (hold_q == HOLD_LAST);
    assign frame_last = (frameIdx == FRAME_LAST);
    // A request in the current cycle counts as well as a remembered one, so a
    // HOLD-cycle keypress reaches DONE on the very next cycle.
    assign exit_now   = exit_q | userCont;
    assign next_frame = frame_last ? '0 : frameIdx + 1'b1;

    always_ff @(posedge clk) begin
        if (stateReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_DRAW;
            S_DRAW: begin
                // The frame is always finished; exit is honoured only after the last address.
                if (draw_last) begin
                    state_d = exit_now ? S_DONE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (exit_now) begin
                    state_d = S_DONE;
                end else if (hold_last) begin
                    state_d = (frame_last && !loop_q) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (stateReset) begin
            romAddr   <= '0;
            memorySel <= '0;
            x         <= '0;
            y         <= '0;
            plot      <= 1'b0;
            frameIdx  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            hold_q    <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            base_q    <= '0;
            loop_q    <= 1'b0;
            exit_q    <= 1'b0;
        end else begin
            // Pixel stage: the ROM data for this address appears next cycle.
            plot <= (state_q == S_DRAW);
            if (state_q == S_DRAW) begin
                x <= x0_q + X_W'(col_q);
                y <= y0_q + Y_W'(row_q);
            end

            if (state_q == S_DONE) begin
                exit_q <= 1'b0;
            end else if (userCont && state_q != S_IDLE) begin
                exit_q <= 1'b1;
            end

            if (state_q == S_IDLE && start) begin
                x0_q      <= x0;
                y0_q      <= y0;
                base_q    <= frameBase;
                loop_q    <= loopMode;
                frameIdx  <= '0;
                memorySel <= frameBase;
            end

            // Frame number and select change only on the HOLD->LOAD edge, so they
            // are stable for a whole LOAD+DRAW+HOLD pass.
            if (state_q == S_HOLD && state_d == S_LOAD) begin
                frameIdx  <= next_frame;
                memorySel <= base_q + SEL_W'(next_frame);
            end

            // Clearing on entry makes romAddr read 0 during LOAD itself.
            if (state_d == S_LOAD) begin
                col_q   <= '0;
                row_q   <= '0;
                romAddr <= '0;
            end else if (state_q == S_DRAW && !draw_last) begin
                romAddr <= romAddr + 1'b1;
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            hold_q <= (state_q == S_HOLD) ? hold_q + 1'b1 : '0;
        end
    end
endmodule
